// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer: default widths and FSM encodings.
package fetch_sequencer_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned BR_W_DEF   = 6;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StWait   = 3'd2,
        StIssue  = 3'd3,
        StDecode = 3'd4,
        StHalt   = 3'd5,
        StErr    = 3'd6
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_next_pc.sv
// Next-PC selection: absolute jump beats relative branch beats sequential increment.
module next_pc_calc
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned BR_W   = BR_W_DEF
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              jmpEnable,
    input  logic [ADDR_W-1:0] jmpDir,
    input  logic              branchEnable,
    input  logic [BR_W-1:0]   branchDir,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] branch_ext;

    // Offset is relative to the branch instruction itself; sum wraps modulo 2^ADDR_W.
    assign branch_ext = {{(ADDR_W - BR_W){branchDir[BR_W-1]}}, branchDir};

    always_comb begin
        next_pc = pc + ADDR_W'(1);
        if (jmpEnable) begin
            next_pc = jmpDir;
        end else if (branchEnable) begin
            next_pc = pc + branch_ext;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: fetches words over req/ack, issues them to decodec and
// picks the next PC from decodec's jump/branch outputs.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned       ADDR_W      = ADDR_W_DEF,
    parameter int unsigned       DATA_W      = DATA_W_DEF,
    parameter int unsigned       BR_W        = BR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int unsigned       MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              stall,
    input  logic              jmpEnable,
    input  logic [ADDR_W-1:0] jmpDir,
    input  logic              branchEnable,
    input  logic [BR_W-1:0]   branchDir,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] next_pc;

    next_pc_calc #(
        .ADDR_W (ADDR_W),
        .BR_W   (BR_W)
    ) u_next_pc (
        .pc           (pc_q),
        .jmpEnable    (jmpEnable),
        .jmpDir       (jmpDir),
        .branchEnable (branchEnable),
        .branchDir    (branchDir),
        .next_pc      (next_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // An ack on the final counted cycle still completes the fetch.
                if (imem_ack) begin
                    instr_d = imem_data;
                    state_d = StIssue;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TIMEOUT_CNT) begin
                        state_d = StErr;
                    end
                end
            end
            StIssue: begin
                if (!stall) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (halt_req) begin
                    state_d = StHalt;
                end else begin
                    pc_d    = next_pc;
                    addr_d  = next_pc;
                    state_d = StFetch;
                end
            end
            StHalt:  state_d = StHalt;
            StErr:   state_d = StErr;
            default: state_d = StIdle;
        endcase
    end

    // Request is decoded from state so an async reset drops it without waiting for ack.
    assign imem_req    = (state_q == StFetch) || (state_q == StWait);
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == StIssue);
    assign pc          = pc_q;
    assign halted      = (state_q == StHalt) || (state_q == StErr);
    assign err         = (state_q == StErr);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table for next-PC selection plus stall,
// halt, timeout, ack-at-limit and mid-fetch reset sequences.
module tb_fetch_sequencer;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int BR_W   = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_data;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              stall = 1'b0;
    logic              jmpEnable = 1'b0;
    logic [ADDR_W-1:0] jmpDir = '0;
    logic              branchEnable = 1'b0;
    logic [BR_W-1:0]   branchDir = '0;
    logic              halt_req = 1'b0;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              err;

    logic ack_auto  = 1'b1;
    logic ack_force = 1'b0;
    logic req_d1    = 1'b0;
    int   cyc       = 0;
    int   n_total   = 0;
    int   n_pass    = 0;

    fetch_sequencer #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BR_W        (BR_W),
        .RESET_PC    (10'd0),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .jmpEnable    (jmpEnable),
        .jmpDir       (jmpDir),
        .branchEnable (branchEnable),
        .branchDir    (branchDir),
        .halt_req     (halt_req),
        .pc           (pc),
        .halted       (halted),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: acks in the cycle after the request is first seen.
    always @(posedge clk or posedge reset) begin
        if (reset) req_d1 <= 1'b0;
        else       req_d1 <= imem_req;
    end

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {~a[5:0], a};
    endfunction

    assign imem_ack  = imem_req && (ack_auto ? req_d1 : ack_force);
    assign imem_data = mem_word(imem_addr);

    typedef struct {
        logic              jmp;
        logic [ADDR_W-1:0] jdir;
        logic              br;
        logic [BR_W-1:0]   bdir;
        logic [ADDR_W-1:0] exp_pc;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic clear_dec();
        jmpEnable    = 1'b0;
        jmpDir       = '0;
        branchEnable = 1'b0;
        branchDir    = '0;
        halt_req     = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int k;
        ok = 1'b0;
        k  = 0;
        while (!ok && k < 20) begin
            @(negedge clk);
            ok = instr_valid;
            k++;
        end
    endtask

    task automatic wait_req(output bit ok);
        int k;
        ok = 1'b0;
        k  = 0;
        while (!ok && k < 20) begin
            @(negedge clk);
            ok = imem_req;
            k++;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        ack_force = 1'b0;
        stall     = 1'b0;
        clear_dec();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit                ok;
        logic [ADDR_W-1:0] cur;
        logic [DATA_W-1:0] saved;
        int                last_cyc;
        int                n;

        //          jmp   jdir     br    bdir          exp_pc
        vecs[0]  = '{1'b0, 10'h000, 1'b0, 6'd0,        10'd1};
        vecs[1]  = '{1'b0, 10'h000, 1'b0, 6'd0,        10'd2};
        vecs[2]  = '{1'b0, 10'h000, 1'b0, 6'd0,        10'd3};
        vecs[3]  = '{1'b1, 10'h005, 1'b0, 6'd0,        10'd5};
        vecs[4]  = '{1'b1, 10'h3F0, 1'b1, 6'd1,        10'h3F0};
        vecs[5]  = '{1'b1, 10'h004, 1'b0, 6'd0,        10'd4};
        vecs[6]  = '{1'b0, 10'h000, 1'b1, 6'b111110,   10'd2};
        vecs[7]  = '{1'b1, 10'd1020, 1'b0, 6'd0,       10'd1020};
        vecs[8]  = '{1'b0, 10'h000, 1'b1, 6'd10,       10'd6};
        vecs[9]  = '{1'b1, 10'd1023, 1'b0, 6'd0,       10'd1023};
        vecs[10] = '{1'b0, 10'h000, 1'b0, 6'd0,        10'd0};
        vecs[11] = '{1'b0, 10'h000, 1'b1, 6'd31,       10'd31};
        vecs[12] = '{1'b0, 10'h000, 1'b1, 6'b100000,   10'd1023};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;

        cur      = '0;
        last_cyc = 0;
        for (int i = 0; i < 13; i++) begin
            wait_valid(ok);
            check($sformatf("v%0d_valid_seen", i), 32'(ok), 32'd1);
            check($sformatf("v%0d_instr", i), 32'(instr), 32'(mem_word(cur)));
            check($sformatf("v%0d_pc", i), 32'(pc), 32'(cur));
            if (i > 0) check($sformatf("v%0d_period", i), 32'(cyc - last_cyc), 32'd4);
            last_cyc     = cyc;
            jmpEnable    = vecs[i].jmp;
            jmpDir       = vecs[i].jdir;
            branchEnable = vecs[i].br;
            branchDir    = vecs[i].bdir;
            @(negedge clk);
            check($sformatf("v%0d_decode_valid", i), 32'(instr_valid), 32'd0);
            check($sformatf("v%0d_decode_req", i), 32'(imem_req), 32'd0);
            @(negedge clk);
            clear_dec();
            check($sformatf("v%0d_fetch_req", i), 32'(imem_req), 32'd1);
            check($sformatf("v%0d_fetch_addr", i), 32'(imem_addr), 32'(vecs[i].exp_pc));
            check($sformatf("v%0d_next_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
            cur = vecs[i].exp_pc;
        end

        // Halt outranks a simultaneous jump; pc holds.
        wait_valid(ok);
        check("halt_valid_seen", 32'(ok), 32'd1);
        halt_req  = 1'b1;
        jmpEnable = 1'b1;
        jmpDir    = 10'h055;
        repeat (2) @(negedge clk);
        clear_dec();
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_pc", 32'(pc), 32'(cur));
        check("halt_req", 32'(imem_req), 32'd0);
        repeat (3) @(negedge clk);
        check("halt_sticky", 32'(halted), 32'd1);
        check("halt_no_err", 32'(err), 32'd0);
        check("halt_req_later", 32'(imem_req), 32'd0);

        // Stall holds ISSUE.
        do_reset();
        wait_valid(ok);
        check("stall_valid_seen", 32'(ok), 32'd1);
        saved = instr;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_valid", k), 32'(instr_valid), 32'd1);
            check($sformatf("stall%0d_instr", k), 32'(instr), 32'(saved));
            check($sformatf("stall%0d_req", k), 32'(imem_req), 32'd0);
        end
        stall = 1'b0;
        @(negedge clk);
        check("stall_release_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("stall_next_addr", 32'(imem_addr), 32'd1);

        // Memory never acks: error after 15 WAIT cycles.
        ack_auto = 1'b0;
        do_reset();
        wait_req(ok);
        check("to_req_seen", 32'(ok), 32'd1);
        n = 0;
        while (!err && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("to_cycles", 32'(n), 32'd16);
        check("to_err", 32'(err), 32'd1);
        check("to_halted", 32'(halted), 32'd1);
        check("to_req", 32'(imem_req), 32'd0);

        // Ack on the last counted WAIT cycle completes the fetch.
        do_reset();
        wait_req(ok);
        check("lim_req_seen", 32'(ok), 32'd1);
        repeat (15) @(negedge clk);
        check("lim_still_wait", 32'(imem_req), 32'd1);
        check("lim_no_err_yet", 32'(err), 32'd0);
        ack_force = 1'b1;
        @(negedge clk);
        ack_force = 1'b0;
        check("lim_valid", 32'(instr_valid), 32'd1);
        check("lim_err", 32'(err), 32'd0);
        check("lim_instr", 32'(instr), 32'(mem_word(10'd0)));

        // Reset mid-WAIT drops the request at once.
        ack_auto = 1'b1;
        do_reset();
        wait_valid(ok);
        check("mid_valid_seen", 32'(ok), 32'd1);
        jmpEnable = 1'b1;
        jmpDir    = 10'h155;
        repeat (2) @(negedge clk);
        clear_dec();
        check("mid_pc_moved", 32'(pc), 32'h155);
        ack_auto = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_in_wait", 32'(imem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_req_drop", 32'(imem_req), 32'd0);
        check("mid_pc_reset", 32'(pc), 32'd0);
        check("mid_addr_reset", 32'(imem_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that sequences the decodec stage.
- Holds the 10-bit program counter and fetches 16-bit words from instruction memory over a req/ack handshake.
- Presents each word to decodec, then samples decodec's jmpEnable/branchEnable one cycle later to pick the next PC.
- Supports downstream stall, halt, and a memory-ack timeout error.

Parameters:
- ADDR_W, 10, PC and instruction-memory address width (matches jmpDir).
- DATA_W, 16, instruction word width (matches decodec in).
- BR_W, 6, branch offset width (matches branchDir).
- RESET_PC, 0, PC value loaded on reset.
- MEM_TIMEOUT, 15, max cycles waiting for imem_ack before error (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch address; equals pc while imem_req is high.
- imem_ack  in  1  memory ack; imem_data valid in the same cycle.
- imem_data  in  DATA_W  fetched instruction word.
- instr  out  DATA_W  instruction to decodec in; registered.
- instr_valid  out  1  instr holds a new word for decodec.
- stall  in  1  downstream not ready; holds the ISSUE state.
- jmpEnable  in  1  from decodec: absolute jump.
- jmpDir  in  ADDR_W  from decodec: absolute jump target.
- branchEnable  in  1  from decodec: branch taken (flags already evaluated).
- branchDir  in  BR_W  from decodec: signed branch offset.
- halt_req  in  1  halt request, sampled in DECODE.
- pc  out  ADDR_W  current PC.
- halted  out  1  sequencer is in HALT.
- err  out  1  memory timeout occurred; sticky until reset.

Behaviour:
- Reset (async, active-high): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, imem_addr=RESET_PC, halted=0, err=0, timeout counter=0.
- Reset asserted mid-fetch: imem_req drops immediately, with no wait for ack. A late ack after reset is ignored in IDLE.
- IDLE: one cycle, then FETCH.
- FETCH: imem_req=1, imem_addr=pc, counter cleared, then WAIT.
- WAIT:
  - imem_req stays 1.
  - If imem_ack: latch instr<=imem_data and go to ISSUE.
  - Otherwise the counter increments. When it reaches MEM_TIMEOUT, go to ERR.
  - An ack in the same cycle the counter hits MEM_TIMEOUT wins, and the fetch completes normally.
- ISSUE:
  - instr_valid=1, imem_req=0.
  - If stall=1, remain in ISSUE with instr and instr_valid held.
  - Otherwise go to DECODE.
- DECODE:
  - instr_valid=0. This is one cycle for decodec's registered outputs to settle.
  - Sample halt_req, jmpEnable and branchEnable, in priority order:
    - halt_req: go to HALT; pc unchanged.
    - jmpEnable: pc<=jmpDir.
    - branchEnable: pc<=pc + sign-extended branchDir, modulo 2^ADDR_W. The offset is relative to the branch instruction's own address.
    - Otherwise: pc<=pc+1; 1023 wraps to 0.
  - Next state is FETCH.
  - Simultaneous jmpEnable and branchEnable: the jump wins.
- HALT: halted=1, no requests, stays until reset.
- ERR: err=1, halted=1, imem_req=0, stays until reset.
- imem_addr is a registered copy of pc, updated in the DECODE→FETCH transition.
- Per-instruction latency with no stall and ack in the first WAIT cycle: FETCH(1) + WAIT(1) + ISSUE(1) + DECODE(1) = 4 cycles.

Decomposition:
- Shared package/def include holds:
  - state encodings: IDLE=0, FETCH=1, WAIT=2, ISSUE=3, DECODE=4, HALT=5, ERR=6 (3 bits);
  - ADDR_W, DATA_W, BR_W defaults.
- One natural sub-module: next_pc_calc, combinational.
  - Inputs: pc, jmpEnable, jmpDir, branchEnable, branchDir.
  - Output: next pc with priority and wrap applied.
- FSM, counter and registers stay in fetch_sequencer.

Test Plan:
- Reset, memory acks every request after 1 cycle, decodec inputs idle, pc=0 → imem_addr goes 0,1,2,3 on successive FETCHes; instr_valid pulses once every 4 cycles; instr matches imem_data.
- pc=5, DECODE sees jmpEnable=1, jmpDir=10'h3F0 → next imem_addr=10'h3F0; same test with branchEnable=1 also high → still 10'h3F0.
- pc=4, branchDir=6'b111110 (−2) → next pc=2. pc=1020, branchDir=6'd10 → next pc=6 (wrap).
- pc=1023, no jump or branch → next pc=0.
- stall=1 for 3 cycles during ISSUE → instr_valid held high 4 cycles, instr unchanged, no new imem_req.
- imem_ack never asserted, MEM_TIMEOUT=15 → err=1 and halted=1 after 15 WAIT cycles. Reset pulse mid-WAIT on a separate run → imem_req=0 immediately, pc=RESET_PC.
